sdram_init_seq: RTL and testbench



---
 rtl/sdram_pkg.sv | 44 ++++
 rtl/sdram_tmr.sv | 26 ++
 rtl/sdram_init_seq.sv | 120 ++++++++++++
 tb/tb_sdram_init_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command codes, mode-register fields and FSM state encoding
package sdram_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MSET = 4'b0000;

    localparam logic [2:0] BL_1    = 3'b000;
    localparam logic [2:0] BL_2    = 3'b001;
    localparam logic [2:0] BL_4    = 3'b010;
    localparam logic [2:0] BL_8    = 3'b011;
    localparam logic [2:0] BL_PAGE = 3'b111;

    localparam logic BT_SEQ = 1'b0;
    localparam logic BT_INT = 1'b1;

    localparam logic [2:0] CL_2 = 3'b010;
    localparam logic [2:0] CL_3 = 3'b011;

    localparam logic WB_BURST  = 1'b0;
    localparam logic WB_SINGLE = 1'b1;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_PRE,
        S_TRP,
        S_AREF,
        S_TRFC,
        S_MRS,
        S_TMRD,
        S_DONE
    } state_e;

    function automatic logic [12:0] mode_word(input logic [2:0] bl, input logic bt, input logic [2:0] cl, input logic wb);
        return {3'b000, wb, 2'b00, cl, bt, bl};
    endfunction

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/sdram_tmr.sv
// sdram_tmr: loadable down-counter that stops at zero and flags it
module sdram_tmr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign zero_o = cnt_q == '0;

    // load wins; otherwise count down and hold at zero
    always_comb begin
        cnt_d = ld_i ? ld_val_i : zero_o ? cnt_q : cnt_q - 1'b1;
    end

    // counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up sequencer (wait, precharge-all, N auto-refreshes, mode-register set)
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int          T_PWRUP_CYC = 20000,
    parameter int          T_RP_CYC    = 2,
    parameter int          T_RFC_CYC   = 7,
    parameter int          T_MRD_CYC   = 2,
    parameter int          AREF_NUM    = 2,
    parameter int          ROW_W       = 13,
    parameter int          BA_W        = 2,
    parameter logic [12:0] MODE_VAL    = mode_word(BL_4, BT_SEQ, CL_3, WB_BURST)
) (
    input  logic             sclk,
    input  logic             s_rst,
    input  logic             init_req,
    output logic [3:0]       cmd_reg,
    output logic [ROW_W-1:0] sdram_addr,
    output logic [BA_W-1:0]  sdram_ba,
    output logic             flag_init_end,
    output logic             init_busy
);
    localparam int TW = $clog2(imax(imax(T_PWRUP_CYC, T_RFC_CYC), imax(T_RP_CYC, T_MRD_CYC)) + 1);
    // wait states are entered one cycle after their command and leave on the edge after zero
    localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP_CYC - 1);
    localparam logic [TW-1:0] LD_RP    = TW'(T_RP_CYC > 1 ? T_RP_CYC - 2 : 0);
    localparam logic [TW-1:0] LD_RFC   = TW'(T_RFC_CYC > 1 ? T_RFC_CYC - 2 : 0);
    localparam logic [TW-1:0] LD_MRD   = TW'(T_MRD_CYC > 1 ? T_MRD_CYC - 2 : 0);
    localparam logic [ROW_W-1:0] ADDR_MODE = ROW_W'(MODE_VAL);
    localparam logic [ROW_W-1:0] ADDR_A10  = ROW_W'(1) << 10;

    if (T_PWRUP_CYC < 1 || T_RP_CYC < 1 || T_RFC_CYC < 1 || T_MRD_CYC < 1 ||
        AREF_NUM < 1 || AREF_NUM > 15 || ROW_W < 11 || BA_W < 1) begin : g_param_chk
        $error("sdram_init_seq: parameter out of range");
    end

    state_e          state_q, state_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [3:0]      ref_cnt_q, ref_cnt_d;
    logic            flag_q, flag_d;
    logic            arm_q;
    logic            tmr_ld, tmr_zero;
    logic [TW-1:0]   tmr_ld_val;
    logic            refs_done;

    assign refs_done = ref_cnt_q == 4'(AREF_NUM);

    sdram_tmr #(.W(TW)) u_tmr (
        .clk_i    (sclk),
        .rst_i    (s_rst),
        .ld_i     (tmr_ld),
        .ld_val_i (tmr_ld_val),
        .zero_o   (tmr_zero)
    );

    // state, registered outputs and refresh count; arm_q marks the power-up timer as loaded
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= S_PWRUP;
            cmd_q     <= NOP;
            flag_q    <= 1'b0;
            ref_cnt_q <= '0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            flag_q    <= flag_d;
            ref_cnt_q <= ref_cnt_d;
            arm_q     <= 1'b1;
        end
    end

    // next state and timer loads; a one-cycle gap bypasses its wait state
    always_comb begin
        state_d    = state_q;
        tmr_ld     = 1'b0;
        tmr_ld_val = '0;
        case (state_q)
            S_PWRUP: begin
                tmr_ld     = !arm_q;
                tmr_ld_val = LD_PWRUP;
                if (arm_q && tmr_zero) state_d = S_PRE;
            end
            S_PRE: begin
                tmr_ld     = T_RP_CYC > 1;
                tmr_ld_val = LD_RP;
                state_d    = T_RP_CYC > 1 ? S_TRP : S_AREF;
            end
            S_TRP: if (tmr_zero) state_d = S_AREF;
            S_AREF: begin
                tmr_ld     = T_RFC_CYC > 1;
                tmr_ld_val = LD_RFC;
                state_d    = T_RFC_CYC > 1 ? S_TRFC : refs_done ? S_MRS : S_AREF;
            end
            S_TRFC: if (tmr_zero) state_d = refs_done ? S_MRS : S_AREF;
            S_MRS: begin
                tmr_ld     = T_MRD_CYC > 1;
                tmr_ld_val = LD_MRD;
                state_d    = T_MRD_CYC > 1 ? S_TMRD : S_DONE;
            end
            S_TMRD: if (tmr_zero) state_d = S_DONE;
            S_DONE: if (init_req) state_d = S_PRE;
            default: state_d = S_PWRUP;
        endcase
    end

    // outputs are decoded from the state being entered so they register alongside it
    always_comb begin
        cmd_d     = state_d == S_PRE ? PRE : state_d == S_AREF ? AREF : state_d == S_MRS ? MSET : NOP;
        flag_d    = state_d == S_DONE;
        ref_cnt_d = state_d == S_PRE ? 4'd0 : state_d == S_AREF ? ref_cnt_q + 4'd1 : ref_cnt_q;
    end

    assign cmd_reg       = cmd_q;
    assign sdram_addr    = cmd_q == MSET ? ADDR_MODE : ADDR_A10;
    assign sdram_ba      = '0;
    assign flag_init_end = flag_q;
    assign init_busy     = !flag_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: scoreboard bench for the SDRAM init sequencer in three configurations
module tb_sdram_init_seq;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MSET = 4'b0000;

    typedef struct {
        int         c;
        logic [3:0] cmd;
        logic       fl;
        int         addr;
    } ev_t;

    logic        sclk = 1'b0;
    logic        rst_a = 1'b1, rst_bc = 1'b1, req_a = 1'b0, req_0 = 1'b0;
    logic [3:0]  cmd_a, cmd_b, cmd_c;
    logic [12:0] addr_a, addr_b;
    logic [11:0] addr_c;
    logic [1:0]  ba_a, ba_b, ba_c;
    logic        fl_a, fl_b, fl_c, bz_a, bz_b, bz_c;
    logic        pf_a = 1'b0, pf_b = 1'b0, pf_c = 1'b0;
    int          cyc_a = -1, cyc_bc = -1;
    int          n_pass = 0, n_chk = 0;
    ev_t         qa[$], qb[$], qc[$];

    always #5 sclk = ~sclk;

    sdram_init_seq u_a (
        .sclk(sclk), .s_rst(rst_a), .init_req(req_a), .cmd_reg(cmd_a),
        .sdram_addr(addr_a), .sdram_ba(ba_a), .flag_init_end(fl_a), .init_busy(bz_a)
    );

    sdram_init_seq #(
        .T_PWRUP_CYC(10), .T_RP_CYC(1), .T_RFC_CYC(1), .T_MRD_CYC(1), .AREF_NUM(1)
    ) u_b (
        .sclk(sclk), .s_rst(rst_bc), .init_req(req_0), .cmd_reg(cmd_b),
        .sdram_addr(addr_b), .sdram_ba(ba_b), .flag_init_end(fl_b), .init_busy(bz_b)
    );

    sdram_init_seq #(
        .T_PWRUP_CYC(10), .T_RP_CYC(3), .T_RFC_CYC(4), .T_MRD_CYC(3), .AREF_NUM(3),
        .ROW_W(12), .MODE_VAL(13'h022)
    ) u_c (
        .sclk(sclk), .s_rst(rst_bc), .init_req(req_0), .cmd_reg(cmd_c),
        .sdram_addr(addr_c), .sdram_ba(ba_c), .flag_init_end(fl_c), .init_busy(bz_c)
    );

    always @(posedge sclk) cyc_a <= rst_a ? -1 : cyc_a + 1;
    always @(posedge sclk) cyc_bc <= rst_bc ? -1 : cyc_bc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic push(input int id, input int c, input logic [3:0] cmd, input logic fl, input int addr);
        ev_t e;
        e = '{c, cmd, fl, addr};
        case (id)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic pop(input int id, output bit ok, output ev_t e);
        ok = 1'b1;
        case (id)
            0: if (qa.size() > 0) e = qa.pop_front(); else ok = 1'b0;
            1: if (qb.size() > 0) e = qb.pop_front(); else ok = 1'b0;
            default: if (qc.size() > 0) e = qc.pop_front(); else ok = 1'b0;
        endcase
    endtask

    task automatic push_std(input int id, input int p, input int rp, input int rfc, input int n, input int mrd, input int mode);
        push(id, p, C_PRE, 1'b0, 'h400);
        for (int k = 0; k < n; k++) push(id, p + rp + k * rfc, C_AREF, 1'b0, 'h400);
        push(id, p + rp + n * rfc, C_MSET, 1'b0, mode);
        push(id, p + rp + n * rfc + mrd, C_NOP, 1'b1, 'h400);
    endtask

    task automatic mon(input int id, input int c, input logic [3:0] cmd, input int addr,
                       input logic fl, input logic pf, input int ba, input logic bz);
        ev_t   e;
        bit    ok;
        string t;
        t = $sformatf("dut%0d@%0d", id, c);
        chk({t, " ba"}, ba, 0);
        chk({t, " busy"}, int'(bz), int'(!fl));
        if (cmd != C_NOP || fl != pf) begin
            pop(id, ok, e);
            if (!ok) begin
                n_chk++;
                $display("FAIL %s unexpected: got cmd %b flag %b, expected no event", t, cmd, fl);
            end else begin
                chk({t, " cycle"}, c, e.c);
                chk({t, " cmd"}, int'(cmd), int'(e.cmd));
                chk({t, " flag"}, int'(fl), int'(e.fl));
                chk({t, " addr"}, addr, e.addr);
            end
        end else begin
            chk({t, " idle addr"}, addr, 'h400);
        end
    endtask

    always @(negedge sclk) begin
        if (!rst_a) mon(0, cyc_a, cmd_a, int'(addr_a), fl_a, pf_a, int'(ba_a), bz_a);
        if (!rst_bc) begin
            mon(1, cyc_bc, cmd_b, int'(addr_b), fl_b, pf_b, int'(ba_b), bz_b);
            mon(2, cyc_bc, cmd_c, int'(addr_c), fl_c, pf_c, int'(ba_c), bz_c);
        end
        pf_a = fl_a;
        pf_b = fl_b;
        pf_c = fl_c;
    end

    task automatic wait_a(input int n);
        while (cyc_a < n) @(negedge sclk);
    endtask

    task automatic pulse_a();
        #1 req_a = 1'b1;
        @(negedge sclk);
        #1 req_a = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge sclk);
        #1;
        chk("rst cmd_a", int'(cmd_a), int'(C_NOP));
        chk("rst flag_a", int'(fl_a), 0);
        chk("rst busy_a", int'(bz_a), 1);
        chk("rst addr_a", int'(addr_a), 'h400);
        chk("rst ba_a", int'(ba_a), 0);
        chk("rst cmd_c", int'(cmd_c), int'(C_NOP));
        chk("rst addr_c", int'(addr_c), 'h400);
        push_std(0, 20000, 2, 7, 2, 2, 'h032);
        push_std(1, 10, 1, 1, 1, 1, 'h032);
        push_std(2, 10, 3, 4, 3, 3, 'h022);
        rst_a  = 1'b0;
        rst_bc = 1'b0;
        wait_a(20005);
        pulse_a();
        wait_a(20100);
        chk("default seq drained", qa.size(), 0);
        chk("done before reinit", int'(fl_a), 1);
        push_std(0, 20101, 2, 7, 2, 2, 'h032);
        pulse_a();
        wait_a(20130);
        chk("reinit seq drained", qa.size(), 0);
        #2 rst_a = 1'b1;
        #1;
        chk("async rst flag", int'(fl_a), 0);
        chk("async rst busy", int'(bz_a), 1);
        repeat (3) @(negedge sclk);
        #1 rst_a = 1'b0;
        push_std(0, 20000, 2, 7, 2, 2, 'h032);
        wait_a(20009);
        #2 rst_a = 1'b1;
        #1;
        chk("mid rst cmd", int'(cmd_a), int'(C_NOP));
        chk("mid rst flag", int'(fl_a), 0);
        chk("mid rst pending", qa.size(), 2);
        qa.delete();
        repeat (3) @(negedge sclk);
        #1 rst_a = 1'b0;
        push_std(0, 20000, 2, 7, 2, 2, 'h032);
        wait_a(20030);
        chk("restart seq drained", qa.size(), 0);
        chk("fast seq drained", qb.size(), 0);
        chk("mode seq drained", qc.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
